// File: rtl/wb_streamer_pkg.sv
// Shared constants for the Wishbone stream DMA blocks: CTI codes, register
// offsets and the burst sequencer state encoding.
package wb_streamer_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_IRQ_EN     = 8'h04;
    localparam logic [7:0] REG_BUF_SIZE   = 8'h08;
    localparam logic [7:0] REG_BURST_SIZE = 8'h0C;
    localparam logic [7:0] REG_START_ADR  = 8'h10;
    localparam logic [7:0] REG_WORD_CNT   = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stream_fifo_fwft.sv
// First-word-fall-through FIFO: dout shows the head word whenever !empty.
// A push is accepted while full if a pop happens in the same cycle.
module stream_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_reader.sv
// Stream-to-memory DMA: buffers a valid/ready stream in a FIFO and writes it
// out as Wishbone incrementing bursts to a programmable memory buffer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | not busy, waiting for a start write to CTRL
// ST_WAIT  | waiting until the FIFO holds a whole burst (min(burst, remaining))
// ST_BURST | cyc/stb asserted, one FIFO word written per ack
// ST_DONE  | sets done, returns to idle
module wb_stream_reader
    import wb_streamer_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_DW-1:0]     stream_s_data_i,
    input  logic                 stream_s_valid_i,
    output logic                 stream_s_ready_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_AW-1:0]     wbs_adr_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic [2:0]           wbs_cti_i,
    input  logic [1:0]           wbs_bte_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic                 wbs_rty_o,
    output logic                 irq_o
);
    localparam int WSB    = WB_DW / 8;
    localparam int WSB_SH = $clog2(WSB);

    function automatic logic [WB_DW-1:0] clamp_burst(input logic [WB_DW-1:0] v);
        if (v == '0) begin
            return WB_DW'(1);
        end else if (v > WB_DW'(MAX_BURST_LEN)) begin
            return WB_DW'(MAX_BURST_LEN);
        end
        return v;
    endfunction

    state_e           state_q, state_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_DW-1:0] remaining_q, remaining_d;
    logic [WB_DW-1:0] beats_q, beats_d;
    logic [WB_DW-1:0] word_cnt_q, word_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             wbs_ack_q;
    logic [WB_DW-1:0] wbs_dat_q;
    logic             irq_en_q;
    logic [WB_DW-1:0] buf_size_q;
    logic [WB_DW-1:0] burst_size_q;
    logic [WB_AW-1:0] start_adr_q;

    logic             wbs_req, wbs_wr, ctrl_wr, start_req, busy, in_burst;
    logic [7:0]       reg_adr;
    logic [WB_DW-1:0] rd_data;
    logic [WB_DW-1:0] burst_len;
    logic [WB_DW-1:0] buf_words;
    logic [WB_DW-1:0] fifo_level;

    logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [WB_DW-1:0] fifo_dout;
    logic [FIFO_AW:0] fifo_count;

    // Ready also rises in a full cycle that pops, since that pop frees a slot.
    assign stream_s_ready_o = !fifo_full || fifo_pop;
    assign fifo_push        = stream_s_valid_i && stream_s_ready_o;

    stream_fifo_fwft #(
        .WIDTH (WB_DW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_push),
        .din   (stream_s_data_i),
        .full  (fifo_full),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_level = {{(WB_DW-FIFO_AW-1){1'b0}}, fifo_count};
    assign burst_len  = (burst_size_q < remaining_q) ? burst_size_q : remaining_q;
    assign buf_words  = buf_size_q >> WSB_SH;

    assign wbs_req   = wbs_cyc_i && wbs_stb_i && !wbs_ack_q;
    assign wbs_wr    = wbs_req && wbs_we_i;
    assign reg_adr   = wbs_adr_i[7:0];
    assign busy      = (state_q != ST_IDLE);
    assign ctrl_wr   = wbs_wr && (reg_adr == REG_CTRL);
    assign start_req = ctrl_wr && wbs_dat_i[0] && !busy;

    always_comb begin
        rd_data = '0;
        case (reg_adr)
            REG_CTRL:       rd_data = {{(WB_DW-3){1'b0}}, err_q, done_q, busy};
            REG_IRQ_EN:     rd_data = {{(WB_DW-1){1'b0}}, irq_en_q};
            REG_BUF_SIZE:   rd_data = buf_size_q;
            REG_BURST_SIZE: rd_data = burst_size_q;
            REG_START_ADR:  rd_data = WB_DW'(start_adr_q);
            REG_WORD_CNT:   rd_data = word_cnt_q;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_q    <= 1'b0;
            wbs_dat_q    <= '0;
            irq_en_q     <= 1'b0;
            buf_size_q   <= '0;
            burst_size_q <= WB_DW'(8);
            start_adr_q  <= '0;
        end else begin
            wbs_ack_q <= wbs_req;
            if (wbs_req) begin
                wbs_dat_q <= rd_data;
            end
            if (wbs_wr) begin
                case (reg_adr)
                    REG_IRQ_EN: irq_en_q <= wbs_dat_i[0];
                    REG_BUF_SIZE: if (!busy) buf_size_q <= wbs_dat_i & ~WB_DW'(WSB-1);
                    REG_BURST_SIZE: if (!busy) burst_size_q <= clamp_burst(wbs_dat_i);
                    REG_START_ADR: if (!busy) start_adr_q <= wbs_dat_i[WB_AW-1:0] & ~WB_AW'(WSB-1);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        word_cnt_d  = word_cnt_q;
        err_d       = err_q;
        done_d      = done_q;
        fifo_pop    = 1'b0;
        if (ctrl_wr && wbs_dat_i[1]) begin
            done_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    adr_d       = start_adr_q;
                    remaining_d = buf_words;
                    word_cnt_d  = '0;
                    err_d       = 1'b0;
                    state_d     = (buf_words == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fifo_level >= burst_len) begin
                    beats_d = burst_len;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wbm_ack_i) begin
                    fifo_pop    = 1'b1;
                    adr_d       = adr_q + WB_AW'(WSB);
                    remaining_d = remaining_q - WB_DW'(1);
                    word_cnt_d  = word_cnt_q + WB_DW'(1);
                    beats_d     = beats_q - WB_DW'(1);
                    if (beats_q == WB_DW'(1)) begin
                        state_d = (remaining_q == WB_DW'(1)) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign in_burst  = (state_q == ST_BURST);
    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_we_o  = in_burst;
    assign wbm_sel_o = {WSB{in_burst}};
    assign wbm_bte_o = 2'b00;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = in_burst ? fifo_dout : '0;
    assign wbm_cti_o = !in_burst ? CTI_CLASSIC :
                       (beats_q == WB_DW'(1)) ? CTI_EOB : CTI_INCR;

    assign wbs_ack_o = wbs_ack_q;
    assign wbs_dat_o = wbs_dat_q;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign irq_o     = done_q && irq_en_q;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, wbs_adr_i[WB_AW-1:8], wbs_sel_i, wbs_cti_i,
                             wbs_bte_i, wbm_dat_i, wbm_rty_i, fifo_empty};

endmodule

// File: tb/tb_wb_stream_reader.sv
// Directed bench for wb_stream_reader: a Wishbone memory model with ack/err
// control records every written word and its CTI code.
module tb_wb_stream_reader;

    localparam logic [7:0] A_CTRL  = 8'h00;
    localparam logic [7:0] A_IRQ   = 8'h04;
    localparam logic [7:0] A_BUF   = 8'h08;
    localparam logic [7:0] A_BURST = 8'h0C;
    localparam logic [7:0] A_START = 8'h10;
    localparam logic [7:0] A_WCNT  = 8'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] stream_s_data_i;
    logic        stream_s_valid_i;
    logic        stream_s_ready_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic        irq_o;

    logic        ack_en, err_en, log_clr, err_hit;
    int          err_beat;
    int          beat_n;
    logic [31:0] mem [0:255];
    logic [2:0]  cti_log [0:63];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    wb_stream_reader dut (
        .clk              (clk),
        .rst              (rst),
        .stream_s_data_i  (stream_s_data_i),
        .stream_s_valid_i (stream_s_valid_i),
        .stream_s_ready_o (stream_s_ready_o),
        .wbm_adr_o        (wbm_adr_o),
        .wbm_dat_o        (wbm_dat_o),
        .wbm_sel_o        (wbm_sel_o),
        .wbm_we_o         (wbm_we_o),
        .wbm_cyc_o        (wbm_cyc_o),
        .wbm_stb_o        (wbm_stb_o),
        .wbm_cti_o        (wbm_cti_o),
        .wbm_bte_o        (wbm_bte_o),
        .wbm_dat_i        (wbm_dat_i),
        .wbm_ack_i        (wbm_ack_i),
        .wbm_err_i        (wbm_err_i),
        .wbm_rty_i        (wbm_rty_i),
        .wbs_adr_i        (wbs_adr_i),
        .wbs_dat_i        (wbs_dat_i),
        .wbs_sel_i        (wbs_sel_i),
        .wbs_we_i         (wbs_we_i),
        .wbs_cyc_i        (wbs_cyc_i),
        .wbs_stb_i        (wbs_stb_i),
        .wbs_cti_i        (wbs_cti_i),
        .wbs_bte_i        (wbs_bte_i),
        .wbs_dat_o        (wbs_dat_o),
        .wbs_ack_o        (wbs_ack_o),
        .wbs_err_o        (wbs_err_o),
        .wbs_rty_o        (wbs_rty_o),
        .irq_o            (irq_o)
    );

    // Memory slave: acks every beat combinationally, or errors on a chosen beat.
    assign err_hit   = err_en && (beat_n == err_beat);
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && ack_en && !err_hit;
    assign wbm_err_i = wbm_cyc_o && wbm_stb_o && err_hit;

    always @(posedge clk) begin
        if (log_clr) begin
            beat_n <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            mem[wbm_adr_o[9:2]] <= wbm_dat_o;
            if (beat_n < 64) cti_log[beat_n] <= wbm_cti_o;
            beat_n <= beat_n + 1;
        end
    end

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        int t;
        @(negedge clk);
        wbs_adr_i = {24'h0, a}; wbs_dat_i = d; wbs_we_i = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!wbs_ack_o && t < 8);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (!wbs_ack_o) begin
            n_checks++;
            $display("FAIL wb_write_ack adr=%h got ack=0 want 1", a);
        end
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        int t;
        @(negedge clk);
        wbs_adr_i = {24'h0, a}; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!wbs_ack_o && t < 8);
        d = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        if (!wbs_ack_o) begin
            n_checks++;
            $display("FAIL wb_read_ack adr=%h got ack=0 want 1", a);
        end
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stream_s_data_i = base + 32'(i); stream_s_valid_i = 1'b1;
            t = 0;
            while (!stream_s_ready_o && t < 200) begin @(negedge clk); t++; end
            if (!stream_s_ready_o) begin
                n_checks++;
                $display("FAIL push_timeout word=%0d got ready=0 want 1", i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        stream_s_valid_i = 1'b0;
    endtask

    task automatic clear_log();
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int t;
        t = 0;
        do begin wb_read(A_CTRL, s); t++; end while (s[0] && t < 200);
        if (s[0]) begin
            n_checks++;
            $display("FAIL wait_idle got busy=1 want 0 after %0d polls", t);
        end
    endtask

    task automatic check_reg(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_read(a, v);
        n_checks++;
        if (v !== exp) $display("FAIL %s got %h want %h", nm, v, exp);
        else n_pass++;
    endtask

    task automatic check_reset_regs();
        check_reg("rst_ctrl",  A_CTRL,  32'h0);
        check_reg("rst_irqen", A_IRQ,   32'h0);
        check_reg("rst_buf",   A_BUF,   32'h0);
        check_reg("rst_burst", A_BURST, 32'h8);
        check_reg("rst_start", A_START, 32'h0);
        check_reg("rst_wcnt",  A_WCNT,  32'h0);
    endtask

    task automatic check_mem(input string nm, input logic [31:0] adr, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (mem[adr[9:2] + 8'(i)] !== base + 32'(i))
                $display("FAIL %s word %0d got %h want %h", nm, i, mem[adr[9:2] + 8'(i)], base + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || irq_o !== 1'b0)
            $display("FAIL reset_outputs got cyc=%b stb=%b irq=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, irq_o);
        else n_pass++;
        n_checks++;
        if (stream_s_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", stream_s_ready_o);
        else n_pass++;
        check_reset_regs();
    endtask

    task automatic test_config_clamp();
        wb_write(A_BURST, 32'd0);    check_reg("burst_min", A_BURST, 32'd1);
        wb_write(A_BURST, 32'd1000); check_reg("burst_max", A_BURST, 32'd128);
        wb_write(A_BURST, 32'd128);  check_reg("burst_128", A_BURST, 32'd128);
        wb_write(A_BURST, 32'd8);
        wb_write(A_BUF, 32'h2B);     check_reg("buf_align", A_BUF, 32'h28);
        wb_write(A_START, 32'h13);   check_reg("start_align", A_START, 32'h10);
        wb_write(A_IRQ, 32'h0);
    endtask

    task automatic test_basic();
        int eob;
        clear_log();
        wb_write(A_BUF, 32'd128); wb_write(A_START, 32'h40);
        push_words(32, 32'h100);
        n_checks++;
        if (stream_s_ready_o !== 1'b0) $display("FAIL basic_full_ready got %b want 0", stream_s_ready_o);
        else n_pass++;
        wb_write(A_CTRL, 32'h1);
        wait_idle();
        check_mem("basic_mem", 32'h40, 32, 32'h100);
        n_checks++;
        if (beat_n !== 32) $display("FAIL basic_beats got %0d want 32", beat_n); else n_pass++;
        eob = 0;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (cti_log[i] !== ((i % 8 == 7) ? 3'b111 : 3'b010))
                $display("FAIL basic_cti beat %0d got %b want %b", i, cti_log[i], (i % 8 == 7) ? 3'b111 : 3'b010);
            else n_pass++;
            if (cti_log[i] == 3'b111) eob++;
        end
        n_checks++;
        if (eob !== 4) $display("FAIL basic_bursts got %0d want 4", eob); else n_pass++;
        check_reg("basic_stat", A_CTRL, 32'h2);
        check_reg("basic_wcnt", A_WCNT, 32'd32);
        wb_write(A_CTRL, 32'h2);
    endtask

    task automatic test_partial();
        clear_log();
        wb_write(A_BUF, 32'd40); wb_write(A_START, 32'h100);
        push_words(10, 32'h200);
        wb_write(A_CTRL, 32'h1);
        wait_idle();
        n_checks++;
        if (beat_n !== 10) $display("FAIL partial_beats got %0d want 10", beat_n); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cti_log[i] !== ((i == 7 || i == 9) ? 3'b111 : 3'b010))
                $display("FAIL partial_cti beat %0d got %b want %b", i, cti_log[i], (i == 7 || i == 9) ? 3'b111 : 3'b010);
            else n_pass++;
        end
        check_mem("partial_mem", 32'h100, 10, 32'h200);
        check_reg("partial_wcnt", A_WCNT, 32'd10);
        wb_write(A_CTRL, 32'h2);
    endtask

    task automatic test_backpressure();
        clear_log();
        ack_en = 1'b0;
        wb_write(A_BUF, 32'd128); wb_write(A_START, 32'h200);
        wb_write(A_CTRL, 32'h1);
        push_words(32, 32'h300);
        repeat (3) @(negedge clk);
        n_checks++;
        if (stream_s_ready_o !== 1'b0 || wbm_cyc_o !== 1'b1)
            $display("FAIL bp_stalled got ready=%b cyc=%b want 0 1", stream_s_ready_o, wbm_cyc_o);
        else n_pass++;
        ack_en = 1'b1;
        #1;
        n_checks++;
        if (stream_s_ready_o !== 1'b1) $display("FAIL bp_ready_on_ack got %b want 1", stream_s_ready_o);
        else n_pass++;
        wait_idle();
        check_mem("bp_mem", 32'h200, 32, 32'h300);
        n_checks++;
        if (beat_n !== 32) $display("FAIL bp_beats got %0d want 32", beat_n); else n_pass++;
        check_reg("bp_wcnt", A_WCNT, 32'd32);
        wb_write(A_CTRL, 32'h2);
    endtask

    task automatic test_error();
        int t;
        clear_log();
        wb_write(A_BUF, 32'd64); wb_write(A_START, 32'h300);
        push_words(16, 32'h400);
        err_beat = 2; err_en = 1'b1;
        wb_write(A_CTRL, 32'h1);
        t = 0;
        while (wbm_err_i !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_checks++;
        if (wbm_err_i !== 1'b1) $display("FAIL err_seen got err=%b want 1", wbm_err_i); else n_pass++;
        @(negedge clk);
        err_en = 1'b0;
        n_checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)
            $display("FAIL err_cyc_drop got cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o);
        else n_pass++;
        check_reg("err_stat", A_CTRL, 32'h6);
        check_reg("err_wcnt", A_WCNT, 32'd2);
        check_mem("err_mem", 32'h300, 2, 32'h400);
    endtask

    task automatic test_irq_lock();
        wb_write(A_IRQ, 32'h1);
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL irq_from_done got %b want 1", irq_o); else n_pass++;
        wb_write(A_CTRL, 32'h2);
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_clear got %b want 0", irq_o); else n_pass++;
        clear_log();
        ack_en = 1'b0;
        wb_write(A_BUF, 32'd56); wb_write(A_START, 32'h380);
        wb_write(A_CTRL, 32'h1);
        wb_write(A_BUF, 32'h1000);
        check_reg("lock_buf", A_BUF, 32'd56);
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_busy got %b want 0", irq_o); else n_pass++;
        ack_en = 1'b1;
        wait_idle();
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL irq_rise got %b want 1", irq_o); else n_pass++;
        check_reg("irq_stat", A_CTRL, 32'h2);
        check_reg("irq_wcnt", A_WCNT, 32'd14);
        check_mem("retained_mem", 32'h380, 14, 32'h402);
        wb_write(A_CTRL, 32'h2);
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_clear2 got %b want 0", irq_o); else n_pass++;
    endtask

    task automatic test_zero_len();
        clear_log();
        wb_write(A_BUF, 32'd0);
        wb_write(A_CTRL, 32'h1);
        wait_idle();
        check_reg("zero_stat", A_CTRL, 32'h2);
        n_checks++;
        if (beat_n !== 0) $display("FAIL zero_beats got %0d want 0", beat_n); else n_pass++;
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL zero_irq got %b want 1", irq_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        int t;
        ack_en = 1'b0;
        push_words(8, 32'h500);
        wb_write(A_BUF, 32'd32); wb_write(A_START, 32'h0);
        wb_write(A_CTRL, 32'h1);
        t = 0;
        while (!wbm_cyc_o && t < 50) begin @(negedge clk); t++; end
        n_checks++;
        if (wbm_cyc_o !== 1'b1) $display("FAIL ares_cyc_before got %b want 1", wbm_cyc_o); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || irq_o !== 1'b0)
            $display("FAIL ares_outputs got cyc=%b stb=%b irq=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, irq_o);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        ack_en = 1'b1;
        check_reset_regs();
        n_checks++;
        if (stream_s_ready_o !== 1'b1) $display("FAIL ares_ready got %b want 1", stream_s_ready_o);
        else n_pass++;
    endtask

    initial begin
        stream_s_data_i = '0; stream_s_valid_i = 1'b0;
        wbm_dat_i = '0; wbm_rty_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = 3'b000; wbs_bte_i = 2'b00;
        ack_en = 1'b1; err_en = 1'b0; err_beat = 0; log_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_config_clamp();
        test_basic();
        test_partial();
        test_backpressure();
        test_error();
        test_irq_lock();
        test_zero_len();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
